hcordic_result_collector: RTL and testbench
===========================================

# hcordic_result_collector

Downstream capture stage for the HCORDIC pipeline. It edge-detects the descale stage's `done` and latches the 32-bit `x_out`, `y_out`, `z_out` triple into a small first-word-fall-through FIFO. Each result is tagged with a sequence number, and results are handed to the consumer over a valid/ready handshake. Loss is reported through a sticky overflow flag and a drop counter.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of two, 2..16.
- `TAG_W`, default 8: width of the sequence tag.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `x_in` input 32: descaled X result from the pipeline.
- `y_in` input 32: descaled Y result.
- `z_in` input 32: descaled Z result.
- `done` input 1: pipeline result-valid level; a capture happens on its 0→1 transition.
- `res_ready` input 1: consumer accepts the head entry when `res_valid` is also high.
- `ovf_clear` input 1: synchronous clear of `overflow` and `drop_cnt`.
- `res_valid` output 1: FIFO is non-empty.
- `res_x` output 32: X of the head entry; 0 when `res_valid`=0.
- `res_y` output 32: Y of the head entry; 0 when `res_valid`=0.
- `res_z` output 32: Z of the head entry; 0 when `res_valid`=0.
- `res_tag` output TAG_W: sequence tag of the head entry; 0 when `res_valid`=0.
- `level` output clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when a capture is dropped.
- `drop_cnt` output 8: number of dropped captures, saturating at 255.

## Operation
- `done_q` is a registered copy of `done`, reset to 0.
- `push = done & ~done_q`.
  - `done` held high for many cycles gives exactly one push.
  - `done` high coming out of reset gives a push on the first clock after reset deasserts.
- `pop = res_valid & res_ready`.
- Storage: DEPTH entries of {x, y, z, tag}, with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Push when not full:
  - write `{x_in, y_in, z_in, tag_ctr}` at the write pointer;
  - advance the write pointer;
  - increment `tag_ctr`, which wraps 2^TAG_W−1 → 0.
- Push when full and no pop in the same cycle:
  - the entry is dropped;
  - `overflow` ← 1;
  - `drop_cnt` ← `drop_cnt`+1, saturating at 255;
  - `tag_ctr` still increments, so the consumer sees a gap in the tag sequence.
- Push and pop in the same cycle:
  - when full, both succeed and `level` is unchanged;
  - when not full and not empty, both succeed and `level` is unchanged;
  - when empty, `pop` is 0 by definition, so only the push occurs.
- Pop with no push: advance the read pointer, `level` −1.
- `ovf_clear`: on the next edge `overflow` ← 0 and `drop_cnt` ← 0.
  - It has priority over a simultaneous drop in the same cycle; that drop is not recorded.
  - Queued data is unaffected.
- Outputs are combinational from the head entry, gated to 0 when empty. This is first-word-fall-through: no extra read latency.
- Reset values: `res_valid`=0; `res_x`/`res_y`/`res_z`=0; `res_tag`=0; `level`=0; `overflow`=0; `drop_cnt`=0. Internally `tag_ctr`=0, pointers=0, `done_q`=0.
- Reset asserted mid-operation discards all queued entries immediately, asynchronously. Storage contents need not be cleared because the outputs are gated.

## Timing
- Capture latency: if `done` rises and is sampled at edge N, `res_valid` is high and the data is visible after edge N. The consumer can therefore pop at edge N+1.
- Throughput: one push and one pop per cycle. Back-to-back pushes need `done` to toggle low→high; the minimum spacing between pushes is 2 cycles.
- `res_valid` falls after the edge at which the last entry is popped, unless a push occurs at that same edge.
- `level` and `overflow` update at the edge of the triggering event.
- Consumer contract: `res_ready` may be held high continuously. Data is stable while `res_valid`=1 and `res_ready`=0.

## Test plan
- Reset/idle:
  - stimulus: assert `reset` asynchronously mid-cycle.
  - response: all outputs 0 immediately; `level`=0 after deassert.
- Single capture:
  - stimulus: `x_in`=0x3F800000, `y_in`=0x40000000, `z_in`=0xBF000000; `done` rises at edge 5 and is held high for 10 cycles; `res_ready`=0.
  - response: exactly one entry with `res_tag`=0 and `level`=1 after edge 5; a pop at edge 8 returns `res_valid`=0 after that edge.
- Fill and overflow:
  - stimulus: DEPTH=4, `res_ready`=0, 6 `done` pulses with x=1..6.
  - response: `level`=4, `overflow`=1, `drop_cnt`=2; pops return x=1..4 with tags 0..3.
  - follow-up: the next capture carries tag 6.
- Full with simultaneous push+pop:
  - stimulus: FIFO full with x=1..4; a `done` edge coincides with `res_ready`=1.
  - response: `level` stays 4, `overflow` stays 0; drain order is 2,3,4,new.
- Tag wrap:
  - stimulus: TAG_W=8, 257 captures drained continuously.
  - response: tags 0..255 followed by 0.
- Clear priority:
  - stimulus: `ovf_clear`=1 coincides with a drop cycle.
  - response: `overflow`=0 and `drop_cnt`=0 after that edge; `level` unchanged.

Source files
------------

// File: rtl/hcordic_result_collector_if.sv
// Result handshake bundle between the HCORDIC collector and its consumer.
// The collector drives the head entry; the consumer answers with res_ready.
interface hcordic_result_collector_if #(
  parameter int TAG_W = 8
);
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_x;
  logic [31:0]      res_y;
  logic [31:0]      res_z;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output res_valid,
    output res_x,
    output res_y,
    output res_z,
    output res_tag,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_x,
    input  res_y,
    input  res_z,
    input  res_tag,
    output res_ready
  );
endinterface

// File: rtl/hcordic_result_collector.sv
// Captures descaled HCORDIC results on the rising edge of done into a tagged
// first-word-fall-through FIFO, reporting lost captures via overflow/drop_cnt.
module hcordic_result_collector #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                x_in,
  input  logic [31:0]                y_in,
  input  logic [31:0]                z_in,
  input  logic                       done,
  input  logic                       ovf_clear,
  hcordic_result_collector_if.master res,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [31:0]      mem_x   [DEPTH];
  logic [31:0]      mem_y   [DEPTH];
  logic [31:0]      mem_z   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [TAG_W-1:0] tag_ctr;
  logic             done_q;

  logic push, pop, full, empty, push_ok, drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign push    = done & ~done_q;
  assign pop     = ~empty & res.res_ready;
  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_ctr  <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      done_q <= done;
      if (push) begin
        tag_ctr <= tag_ctr + TAG_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + LW'(1);
      end else if (pop && !push_ok) begin
        count <= count - LW'(1);
      end
      // Clearing wins over a drop landing in the same cycle.
      if (ovf_clear) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_x[wr_ptr]   <= x_in;
      mem_y[wr_ptr]   <= y_in;
      mem_z[wr_ptr]   <= z_in;
      mem_tag[wr_ptr] <= tag_ctr;
    end
  end

  assign level         = count;
  assign res.res_valid = ~empty;
  assign res.res_x     = empty ? 32'd0 : mem_x[rd_ptr];
  assign res.res_y     = empty ? 32'd0 : mem_y[rd_ptr];
  assign res.res_z     = empty ? 32'd0 : mem_z[rd_ptr];
  assign res.res_tag   = empty ? '0 : mem_tag[rd_ptr];
endmodule

// File: tb/tb_hcordic_result_collector.sv
// Scoreboard bench for hcordic_result_collector: directed captures queue their
// expected entries, and a monitor compares every accepted head entry.
module tb_hcordic_result_collector;
  localparam int DEPTH = 4;
  localparam int TAG_W = 8;

  typedef struct packed {
    logic [31:0]      x;
    logic [31:0]      y;
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic [31:0] z_in = '0;
  logic        done = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  entry_t exp_q[$];
  logic [TAG_W-1:0] exp_tag = '0;

  hcordic_result_collector_if #(.TAG_W(TAG_W)) res_if ();

  hcordic_result_collector #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .done      (done),
    .ovf_clear (ovf_clear),
    .res       (res_if),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One done pulse: high for one edge, low for the next, so done_q re-arms.
  task automatic capture(input logic [31:0] x, input bit kept);
    entry_t e;
    x_in = x;
    y_in = x + 32'h100;
    z_in = ~x;
    e = '{x: x_in, y: y_in, z: z_in, tag: exp_tag};
    if (kept) exp_q.push_back(e);
    exp_tag = exp_tag + 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    res_if.res_ready = 1'b1;
    while (level != 0 && budget < 50) begin
      tick();
      budget++;
    end
    res_if.res_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    exp_q.delete();
    exp_tag = '0;
    #1;
    check("rst_valid", 32'(res_if.res_valid), 32'd0);
    check("rst_x", res_if.res_x, 32'd0);
    check("rst_tag", 32'(res_if.res_tag), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    check("post_rst_level", 32'(level), 32'd0);
  endtask

  // Monitor: whatever the consumer accepts must be the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && res_if.res_valid && res_if.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(res_if.res_tag), 32'hFFFF_FFFF);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("pop_x", res_if.res_x, e.x);
        check("pop_y", res_if.res_y, e.y);
        check("pop_z", res_if.res_z, e.z);
        check("pop_tag", 32'(res_if.res_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_if.res_ready = 1'b0;
    #2;
    check("init_valid", 32'(res_if.res_valid), 32'd0);
    check("init_level", 32'(level), 32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    check("init_drop_cnt", 32'(drop_cnt), 32'd0);
    #10;
    reset = 1'b0;
    tick();

    // Single capture with done held high: exactly one entry.
    x_in = 32'h3F80_0000;
    y_in = 32'h4000_0000;
    z_in = 32'hBF00_0000;
    exp_q.push_back('{x: 32'h3F80_0000, y: 32'h4000_0000, z: 32'hBF00_0000, tag: 8'd0});
    exp_tag = exp_tag + 1'b1;
    done = 1'b1;
    tick();
    check("single_level", 32'(level), 32'd1);
    check("single_valid", 32'(res_if.res_valid), 32'd1);
    check("single_x", res_if.res_x, 32'h3F80_0000);
    repeat (2) tick();
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("single_after_pop_valid", 32'(res_if.res_valid), 32'd0);
    check("single_after_pop_x", res_if.res_x, 32'd0);
    repeat (6) tick();
    check("held_done_level", 32'(level), 32'd0);
    done = 1'b0;
    tick();

    // Fill and overflow from a clean tag sequence.
    apply_reset();
    for (int i = 1; i <= 6; i++) capture(32'(i), i <= DEPTH);
    check("fill_level", 32'(level), 32'd4);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_drop_cnt", 32'(drop_cnt), 32'd2);
    drain();
    capture(32'd7, 1'b1);
    check("gap_tag", 32'(res_if.res_tag), 32'd6);
    drain();

    // Full FIFO with a push and a pop on the same edge.
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_drop_cnt", 32'(drop_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) capture(32'(i), 1'b1);
    x_in = 32'd5;
    y_in = 32'd5 + 32'h100;
    z_in = ~32'd5;
    exp_q.push_back('{x: x_in, y: y_in, z: z_in, tag: exp_tag});
    exp_tag = exp_tag + 1'b1;
    res_if.res_ready = 1'b1;
    done = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    done = 1'b0;
    check("pushpop_level", 32'(level), 32'd4);
    check("pushpop_overflow", 32'(overflow), 32'd0);
    tick();
    drain();

    // Clear coinciding with a drop: the drop goes unrecorded.
    for (int i = 8; i <= 11; i++) capture(32'(i), 1'b1);
    capture(32'd12, 1'b0);
    check("pre_clear_drop_cnt", 32'(drop_cnt), 32'd1);
    x_in = 32'd13;
    exp_tag = exp_tag + 1'b1;
    ovf_clear = 1'b1;
    done = 1'b1;
    tick();
    ovf_clear = 1'b0;
    done = 1'b0;
    check("prio_overflow", 32'(overflow), 32'd0);
    check("prio_drop_cnt", 32'(drop_cnt), 32'd0);
    check("prio_level", 32'(level), 32'd4);
    tick();
    drain();

    // Tag wrap over 257 continuously drained captures.
    apply_reset();
    res_if.res_ready = 1'b1;
    for (int i = 0; i < 257; i++) capture(32'h1000 + 32'(i), 1'b1);
    repeat (3) tick();
    res_if.res_ready = 1'b0;
    check("wrap_level", 32'(level), 32'd0);
    check("wrap_next_tag", 32'(exp_tag), 32'd1);

    // Mid-operation reset discards queued entries.
    capture(32'hAAAA_0001, 1'b1);
    capture(32'hAAAA_0002, 1'b1);
    check("pre_reset_level", 32'(level), 32'd2);
    apply_reset();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
